// File: rtl/mips_data_mem.sv
// Word-organised data memory behind the mips core's memory stage, plus one
// memory-mapped output register, a sticky bad-store flag and a store counter.
module mips_data_mem #(
    parameter int unsigned depth     = 1024,
    parameter logic [31:0] base_addr = 32'h0000_0000,
    parameter logic [31:0] io_addr   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_rd_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic [31:0] io_out,
    output logic        io_valid,
    output logic        err_store,
    output logic [31:0] err_addr,
    output logic [15:0] wr_count
);
    localparam int unsigned AW        = $clog2(depth);
    localparam logic [31:0] RAM_BYTES = 32'(4 * depth);

    logic [31:0]   offset;
    logic          in_ram;
    logic          is_io;
    logic [AW-1:0] word_idx;
    logic          new_store;

    logic [31:0] mem [depth];
    logic [31:0] ram_rd_q;

    logic        rd_sel_ram_q;
    logic [31:0] rd_other_q;
    logic        prev_wr_q;
    logic [31:0] last_addr_q;
    logic [31:0] last_data_q;
    logic [31:0] io_out_q;
    logic        io_valid_q;
    logic        err_store_q;
    logic [31:0] err_addr_q;
    logic [15:0] wr_count_q;
    logic [15:0] wr_count_d;

    // Addresses below base_addr wrap to a huge offset and fall out of range.
    assign offset    = data_addr - base_addr;
    assign in_ram    = (offset[1:0] == 2'b00) && (offset < RAM_BYTES);
    assign word_idx  = offset[AW+1:2];
    assign is_io     = (data_addr == io_addr);
    assign new_store = !data_rd_wr &&
                       (!prev_wr_q || data_addr != last_addr_q || data_wr != last_data_q);
    assign wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;

    // RAM port kept free of reset so it maps onto block RAM; the read register
    // only loads on RAM reads, so it holds through write cycles.
    always_ff @(posedge clk) begin
        if (!data_rd_wr && in_ram) begin
            mem[word_idx] <= data_wr;
        end
        if (data_rd_wr && in_ram) begin
            ram_rd_q <= mem[word_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_sel_ram_q <= 1'b0;
            rd_other_q   <= 32'h0;
            prev_wr_q    <= 1'b0;
            last_addr_q  <= 32'h0;
            last_data_q  <= 32'h0;
            io_out_q     <= 32'h0;
            io_valid_q   <= 1'b0;
            err_store_q  <= 1'b0;
            err_addr_q   <= 32'h0;
            wr_count_q   <= 16'h0;
        end else begin
            if (data_rd_wr) begin
                rd_sel_ram_q <= in_ram;
                rd_other_q   <= is_io ? io_out_q : 32'h0;
            end
            prev_wr_q   <= !data_rd_wr;
            last_addr_q <= data_addr;
            last_data_q <= data_wr;
            io_valid_q  <= new_store && is_io;
            if (new_store) begin
                if (in_ram) begin
                    wr_count_q <= wr_count_d;
                end else if (is_io) begin
                    io_out_q   <= data_wr;
                    wr_count_q <= wr_count_d;
                end else if (!err_store_q) begin
                    err_store_q <= 1'b1;
                    err_addr_q  <= data_addr;
                end
            end
        end
    end

    assign data_rd   = rd_sel_ram_q ? ram_rd_q : rd_other_q;
    assign io_out    = io_out_q;
    assign io_valid  = io_valid_q;
    assign err_store = err_store_q;
    assign err_addr  = err_addr_q;
    assign wr_count  = wr_count_q;
endmodule
